ssemi_output_fifo: RTL and testbench



---
 rtl/ssemi_afe_pkg.sv | 14 +
 rtl/ssemi_fifo_mem.sv | 27 ++
 rtl/ssemi_output_fifo.sv | 110 +++++++++++
 tb/tb_ssemi_output_fifo.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ssemi_afe_pkg.sv
// rtl/ssemi_afe_pkg.sv - shared types and constants for the AFE decimation output path
package ssemi_afe_pkg;

  localparam int SSEMI_OUTPUT_DATA_WIDTH = 24;
  localparam int SSEMI_DROP_CNT_WIDTH    = 16;

  typedef logic [SSEMI_OUTPUT_DATA_WIDTH-1:0] ssemi_output_data_t;

  // Occupancy needs one extra bit so that a full FIFO (count == depth) is representable.
  function automatic int fifo_level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ssemi_fifo_mem.sv
// rtl/ssemi_fifo_mem.sv - register array, one sync write port, one async read port
module ssemi_fifo_mem #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 24
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]    rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ssemi_output_fifo.sv
// rtl/ssemi_output_fifo.sv - FWFT output buffer behind the halfband filter
// Absorbs non-stallable write pulses, tracks occupancy and counts dropped samples.
module ssemi_output_fifo
  import ssemi_afe_pkg::*;
#(
  parameter int DATA_WIDTH          = SSEMI_OUTPUT_DATA_WIDTH,
  parameter int DEPTH               = 16,
  parameter int ALMOST_FULL_THRESH  = 12,
  parameter int ALMOST_EMPTY_THRESH = 2
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_enable,
  input  logic                            i_flush,
  input  logic                            i_clear_status,
  input  logic                            i_valid,
  input  logic [DATA_WIDTH-1:0]           i_data,
  output logic                            o_ready,
  output logic                            o_valid,
  output logic [DATA_WIDTH-1:0]           o_data,
  input  logic                            i_ready,
  output logic [fifo_level_w(DEPTH)-1:0]  o_level,
  output logic                            o_full,
  output logic                            o_empty,
  output logic                            o_almost_full,
  output logic                            o_almost_empty,
  output logic                            o_overflow,
  output logic [SSEMI_DROP_CNT_WIDTH-1:0] o_drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = fifo_level_w(DEPTH);

  if ((DEPTH & (DEPTH - 1)) != 0 || DEPTH < 4 || DEPTH > 256) begin : g_bad_depth
    $error("ssemi_output_fifo: DEPTH must be a power of 2 in 4..256");
  end
  if (ALMOST_FULL_THRESH < 1 || ALMOST_FULL_THRESH > DEPTH) begin : g_bad_af
    $error("ssemi_output_fifo: ALMOST_FULL_THRESH out of range");
  end
  if (ALMOST_EMPTY_THRESH < 0 || ALMOST_EMPTY_THRESH > DEPTH - 1) begin : g_bad_ae
    $error("ssemi_output_fifo: ALMOST_EMPTY_THRESH out of range");
  end
  if (DATA_WIDTH < 8 || DATA_WIDTH > 48) begin : g_bad_width
    $error("ssemi_output_fifo: DATA_WIDTH out of range");
  end

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic          active, pop, push, drop;

  assign active = i_enable && !i_flush;
  assign pop    = o_valid && i_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push   = active && i_valid && (!o_full || pop);
  assign drop   = active && i_valid && o_full && !pop;

  assign o_full         = (count == LW'(DEPTH));
  assign o_empty        = (count == '0);
  assign o_valid        = i_enable && !o_empty;
  assign o_ready        = i_enable && !o_full;
  assign o_level        = count;
  assign o_almost_full  = (count >= LW'(ALMOST_FULL_THRESH));
  assign o_almost_empty = (count <= LW'(ALMOST_EMPTY_THRESH));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (!active) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + LW'(1);
      else if (pop && !push) count <= count - LW'(1);
    end
  end

  // A drop in the same cycle as a clear wins, leaving a count of one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_overflow   <= 1'b0;
      o_drop_count <= '0;
    end else if (drop) begin
      o_overflow <= 1'b1;
      if (i_clear_status)     o_drop_count <= SSEMI_DROP_CNT_WIDTH'(1);
      else if (~&o_drop_count) o_drop_count <= o_drop_count + SSEMI_DROP_CNT_WIDTH'(1);
    end else if (i_clear_status) begin
      o_overflow   <= 1'b0;
      o_drop_count <= '0;
    end
  end

  ssemi_fifo_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_mem (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (i_data),
    .rd_addr (rd_ptr),
    .rd_data (o_data)
  );

endmodule

// File: tb/tb_ssemi_output_fifo.sv
// tb/tb_ssemi_output_fifo.sv - directed self-checking bench for ssemi_output_fifo
module tb_ssemi_output_fifo;

  logic        i_clk = 1'b0;
  logic        i_rst_n, i_enable, i_flush, i_clear_status, i_valid, i_ready;
  logic [23:0] i_data;
  logic        o_ready, o_valid, o_full, o_empty, o_almost_full, o_almost_empty, o_overflow;
  logic [23:0] o_data;
  logic [4:0]  o_level;
  logic [15:0] o_drop_count;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  ssemi_output_fifo dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_enable       (i_enable),
    .i_flush        (i_flush),
    .i_clear_status (i_clear_status),
    .i_valid        (i_valid),
    .i_data         (i_data),
    .o_ready        (o_ready),
    .o_valid        (o_valid),
    .o_data         (o_data),
    .i_ready        (i_ready),
    .o_level        (o_level),
    .o_full         (o_full),
    .o_empty        (o_empty),
    .o_almost_full  (o_almost_full),
    .o_almost_empty (o_almost_empty),
    .o_overflow     (o_overflow),
    .o_drop_count   (o_drop_count)
  );

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic write_one(input logic [23:0] d);
    i_valid = 1'b1;
    i_data  = d;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_enable = 1'b0; i_flush = 1'b0; i_clear_status = 1'b0;
    i_valid = 1'b0; i_ready = 1'b0; i_data = '0;
    tick(); tick();
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b0 || o_level !== 5'd0 || o_empty !== 1'b1 || o_full !== 1'b0) begin
      errors++;
      $display("FAIL reset_occupancy: valid=%b ready=%b level=%0d empty=%b full=%b, want 0 0 0 1 0",
               o_valid, o_ready, o_level, o_empty, o_full);
    end
    checks++;
    if (o_almost_empty !== 1'b1 || o_almost_full !== 1'b0 || o_overflow !== 1'b0 ||
        o_drop_count !== 16'd0 || o_data !== 24'd0) begin
      errors++;
      $display("FAIL reset_status: ae=%b af=%b ovf=%b drops=%0d data=%h, want 1 0 0 0 000000",
               o_almost_empty, o_almost_full, o_overflow, o_drop_count, o_data);
    end
    i_rst_n = 1'b1;
    tick();
    i_enable = 1'b1;
    #1;
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_on_enable: ready=%b want 1", o_ready);
    end
  endtask

  task automatic test_single();
    write_one(24'h123456);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 24'h123456 || o_level !== 5'd1) begin
      errors++;
      $display("FAIL single_write: valid=%b data=%h level=%0d, want 1 123456 1", o_valid, o_data, o_level);
    end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    checks++;
    if (o_empty !== 1'b1 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_pop: empty=%b valid=%b, want 1 0", o_empty, o_valid);
    end
  endtask

  task automatic test_fill();
    for (int k = 1; k <= 16; k++) begin
      write_one(24'(k));
      checks++;
      if (o_almost_full !== (k >= 12) || o_level !== 5'(k)) begin
        errors++;
        $display("FAIL fill_level_%0d: af=%b level=%0d, want %b %0d", k, o_almost_full, o_level, (k >= 12), k);
      end
    end
    checks++;
    if (o_full !== 1'b1 || o_ready !== 1'b0 || o_data !== 24'd1) begin
      errors++;
      $display("FAIL fill_full: full=%b ready=%b head=%h, want 1 0 000001", o_full, o_ready, o_data);
    end
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 3; k++) write_one(24'hBAD000 + 24'(k));
    checks++;
    if (o_overflow !== 1'b1 || o_drop_count !== 16'd3 || o_level !== 5'd16 || o_data !== 24'd1) begin
      errors++;
      $display("FAIL overflow: ovf=%b drops=%0d level=%0d head=%h, want 1 3 16 000001",
               o_overflow, o_drop_count, o_level, o_data);
    end
  endtask

  task automatic test_full_push_pop();
    i_ready = 1'b1;
    write_one(24'd17);
    i_ready = 1'b0;
    checks++;
    if (o_level !== 5'd16 || o_drop_count !== 16'd3 || o_data !== 24'd2) begin
      errors++;
      $display("FAIL full_push_pop: level=%0d drops=%0d head=%h, want 16 3 000002", o_level, o_drop_count, o_data);
    end
  endtask

  task automatic test_drain();
    i_ready = 1'b1;
    for (int k = 2; k <= 17; k++) begin
      checks++;
      if (o_data !== 24'(k) || o_valid !== 1'b1 || o_almost_empty !== (17 - k + 1 <= 2)) begin
        errors++;
        $display("FAIL drain_%0d: data=%h valid=%b ae=%b, want %h 1 %b",
                 k, o_data, o_valid, o_almost_empty, 24'(k), (17 - k + 1 <= 2));
      end
      tick();
    end
    i_ready = 1'b0;
    checks++;
    if (o_empty !== 1'b1 || o_level !== 5'd0) begin
      errors++;
      $display("FAIL drain_empty: empty=%b level=%0d, want 1 0", o_empty, o_level);
    end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 5; k++) write_one(24'h500 + 24'(k));
    i_flush = 1'b1;
    write_one(24'h999999);
    i_flush = 1'b0;
    checks++;
    if (o_level !== 5'd0 || o_valid !== 1'b0 || o_drop_count !== 16'd3 || o_overflow !== 1'b1) begin
      errors++;
      $display("FAIL flush: level=%0d valid=%b drops=%0d ovf=%b, want 0 0 3 1",
               o_level, o_valid, o_drop_count, o_overflow);
    end
  endtask

  task automatic test_wrap();
    logic [23:0] q[$];
    int sent = 0, got = 0, cyc = 0;
    while (got < 40 && cyc < 300) begin
      i_valid = (cyc % 2 == 0) && (sent < 40);
      i_data  = 24'hA00 + 24'(sent);
      i_ready = (cyc % 2 == 0);
      if (i_ready && q.size() != 0) begin
        checks++;
        if (o_data !== q[0] || o_valid !== 1'b1) begin
          errors++;
          $display("FAIL wrap_order_%0d: data=%h valid=%b, want %h 1", got, o_data, o_valid, q[0]);
        end
        void'(q.pop_front());
        got++;
      end
      if (i_valid) begin
        q.push_back(i_data);
        sent++;
      end
      tick();
      cyc++;
    end
    i_valid = 1'b0; i_ready = 1'b0;
    checks++;
    if (got != 40 || o_level !== 5'd0 || o_drop_count !== 16'd3) begin
      errors++;
      $display("FAIL wrap_done: popped=%0d level=%0d drops=%0d, want 40 0 3", got, o_level, o_drop_count);
    end
  endtask

  task automatic test_clear();
    i_clear_status = 1'b1;
    tick();
    i_clear_status = 1'b0;
    checks++;
    if (o_overflow !== 1'b0 || o_drop_count !== 16'd0) begin
      errors++;
      $display("FAIL clear_status: ovf=%b drops=%0d, want 0 0", o_overflow, o_drop_count);
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 16; k++) write_one(24'hC00 + 24'(k));
    i_valid = 1'b1;
    i_clear_status = 1'b1;
    tick();
    i_clear_status = 1'b0;
    checks++;
    if (o_overflow !== 1'b1 || o_drop_count !== 16'd1) begin
      errors++;
      $display("FAIL clear_vs_drop: ovf=%b drops=%0d, want 1 1", o_overflow, o_drop_count);
    end
    for (int k = 0; k < 65540; k++) tick();
    i_valid = 1'b0;
    checks++;
    if (o_drop_count !== 16'hFFFF || o_data !== 24'hC00) begin
      errors++;
      $display("FAIL drop_saturate: drops=%h head=%h, want ffff 000c00", o_drop_count, o_data);
    end
    test_clear();
  endtask

  task automatic test_async_reset();
    #2;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_level !== 5'd0 || o_data !== 24'd0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: level=%0d data=%h valid=%b, want 0 000000 0", o_level, o_data, o_valid);
    end
    i_rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_overflow();
    test_full_push_pop();
    test_drain();
    test_flush();
    test_wrap();
    test_clear();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
